// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared constants and helpers for prog_counter.
//   DIR_UP/DIR_DOWN   : encoding of the 'up' input
//   MODE_WRAP/MODE_SAT: encoding of the 'sat' input
//   pre_width()       : bit width of the prescaler phase register (>= 1)
package prog_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Width needed to hold 0..p-1; a single-cycle prescaler still gets one bit.
  function automatic int unsigned pre_width(input int unsigned p);
    return (p <= 1) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/prog_counter_prescaler.sv
// prog_counter_prescaler: clock-enable divider for prog_counter.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset (phase -> 0)
//   en      : advance the phase this cycle
//   restart : synchronous return of the phase to 0 (clear/load)
//   tick    : en in the last phase slot (combinational)
module prog_counter_prescaler
  import prog_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned PW = pre_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // Tick on the final enabled slot; with PRESCALE=1 the phase is always 0.
  assign tick = en && (phase == LAST);

  // Phase register: holds when en is low so the phase survives gaps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (restart) begin
      phase <= '0;
    end else if (en) begin
      phase <= tick ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// prog_counter: parametrised up/down counter with programmable terminal value,
// wrap/saturate mode, synchronous clear/load, prescaled enable, terminal-count
// pulse and sticky overflow flag.
// Optional comparator enabled by defining PROG_COUNTER_CMP_EN.
//   clk, rst  : clock (rising edge), asynchronous active-low reset
//   en        : count enable (through the prescaler)
//   up, sat   : direction (1=up) and mode (1=saturate, 0=wrap)
//   clr, load : synchronous clear / load of load_val (clr wins)
//   max_val   : upper bound, lower bound is 0
//   ovf_clr   : clears ovf (a simultaneous boundary event wins)
//   cmp_val   : compare value (PROG_COUNTER_CMP_EN only)
//   count, tc, ovf, cmp_match : registered outputs
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             ovf_clr,
`ifdef PROG_COUNTER_CMP_EN
  input  logic [WIDTH-1:0] cmp_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             cmp_match
);

  logic             tick;
  logic             restart;
  logic             at_bound;
  logic             bnd_evt;
  logic [WIDTH-1:0] count_nxt;

  assign restart = clr | load;

  prog_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .restart (restart),
    .tick    (tick)
  );

  // Next-count selection: clr > load > tick. '>=' also catches count above
  // max_val after a load or a max_val change.
  always_comb begin
    count_nxt = count;
    bnd_evt   = 1'b0;
    at_bound  = (up == DIR_UP) ? (count >= max_val) : (count == '0);
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_val;
    end else if (tick) begin
      bnd_evt = at_bound;
      if (up == DIR_UP) begin
        count_nxt = at_bound ? ((sat == MODE_SAT) ? max_val : '0)
                             : count + WIDTH'(1);
      end else begin
        count_nxt = at_bound ? ((sat == MODE_SAT) ? '0 : max_val)
                             : count - WIDTH'(1);
      end
    end
  end

  // Count, terminal-count pulse and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= bnd_evt;
      ovf   <= bnd_evt | (ovf & ~ovf_clr);
    end
  end

`ifdef PROG_COUNTER_CMP_EN
  // Registered from count_nxt so the match lines up with count itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_match <= 1'b0;
    end else begin
      cmp_match <= (count_nxt == cmp_val);
    end
  end
`else
  assign cmp_match = 1'b0;
`endif

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed and randomized checks of prog_counter against a
// behavioural model; two instances (PRESCALE=1 and PRESCALE=4) share stimulus.
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b1, sat = 1'b0, clr = 1'b0, load = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] load_val = '0, max_val = 8'hff, cmp_val = 8'd5;

  logic [7:0] c1, c4;
  logic       tc1, tc4, ovf1, ovf4, cm1, cm4;

`ifdef PROG_COUNTER_CMP_EN
  localparam bit CMP_ON = 1'b1;
`else
  localparam bit CMP_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  prog_counter #(.WIDTH(8), .PRESCALE(1)) d1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val), .max_val(max_val), .ovf_clr(ovf_clr),
`ifdef PROG_COUNTER_CMP_EN
    .cmp_val(cmp_val),
`endif
    .count(c1), .tc(tc1), .ovf(ovf1), .cmp_match(cm1));

  prog_counter #(.WIDTH(8), .PRESCALE(4)) d4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val), .max_val(max_val), .ovf_clr(ovf_clr),
`ifdef PROG_COUNTER_CMP_EN
    .cmp_val(cmp_val),
`endif
    .count(c4), .tc(tc4), .ovf(ovf4), .cmp_match(cm4));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference state per instance: index 0 -> PRESCALE=1, index 1 -> PRESCALE=4.
  int unsigned m_cnt[2];
  int unsigned m_ph[2];
  bit          m_tc[2], m_ovf[2], m_cmp[2];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_ph[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_cmp[k] = 0;
    end
  endtask

  // One clock edge of the counter, stated in terms of count values and bounds.
  task automatic model_step();
    int unsigned p;
    bit tk, ev;
    for (int k = 0; k < 2; k++) begin
      p  = (k == 0) ? 1 : 4;
      tk = en && (m_ph[k] == p - 1);
      ev = 1'b0;
      if (clr) begin
        m_cnt[k] = 0; m_ph[k] = 0;
      end else if (load) begin
        m_cnt[k] = int'(load_val); m_ph[k] = 0;
      end else begin
        if (en) m_ph[k] = (m_ph[k] + 1) % p;
        if (tk) begin
          if (up) begin
            ev = (m_cnt[k] >= int'(max_val));
            m_cnt[k] = ev ? (sat ? int'(max_val) : 0) : m_cnt[k] + 1;
          end else begin
            ev = (m_cnt[k] == 0);
            m_cnt[k] = ev ? (sat ? 0 : int'(max_val)) : m_cnt[k] - 1;
          end
        end
      end
      m_tc[k] = ev;
      if (ev) m_ovf[k] = 1'b1;
      else if (ovf_clr) m_ovf[k] = 1'b0;
      m_cmp[k] = CMP_ON && (m_cnt[k] == int'(cmp_val));
    end
  endtask

  task automatic check_model();
    check("count_p1", c1, m_cnt[0]);
    check("tc_p1", tc1, m_tc[0]);
    check("ovf_p1", ovf1, m_ovf[0]);
    check("cmp_p1", cm1, m_cmp[0]);
    check("count_p4", c4, m_cnt[1]);
    check("tc_p4", tc4, m_tc[1]);
    check("ovf_p4", ovf4, m_ovf[1]);
    check("cmp_p4", cm4, m_cmp[1]);
  endtask

  // Inputs are set at the falling edge; the model advances on the rising edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    en = 0; clr = 0; load = 0; ovf_clr = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_count", c1, 0);
    check("reset_tc", tc1, 0);
    check("reset_ovf", ovf1, 0);
    check("reset_cmp", cm1, 0);
    @(negedge clk);
    rst = 1;

    // Async reset between edges.
    load_val = 8'h37; load = 1; cycle(); load = 0;
    check("pre_rst_count", c1, 8'h37);
    #2 rst = 0;
    #1;
    model_reset();
    check("async_rst_count", c1, 0);
    check("async_rst_count4", c4, 0);
    check("async_rst_tc", tc1, 0);
    check("async_rst_ovf", ovf1, 0);
    @(negedge clk);
    rst = 1;

    // Up/wrap 0..9,0.
    clr = 1; cycle(); clr = 0;
    up = 1; sat = 0; max_val = 8'd9; en = 1;
    for (int i = 1; i <= 9; i++) begin
      cycle();
      check("upwrap_count", c1, i);
      check("upwrap_tc", tc1, 0);
    end
    cycle();
    check("upwrap_count_wrap", c1, 0);
    check("upwrap_tc_wrap", tc1, 1);
    check("upwrap_ovf", ovf1, 1);
    cycle();
    check("upwrap_tc_once", tc1, 0);
    check("upwrap_ovf_held", ovf1, 1);

    // Down/saturate from 2.
    idle(); load_val = 8'd2; load = 1; cycle(); load = 0;
    up = 0; sat = 1; en = 1;
    cycle(); check("dnsat_c1", c1, 1); check("dnsat_tc1", tc1, 0);
    cycle(); check("dnsat_c0", c1, 0); check("dnsat_tc0", tc1, 0);
    cycle(); check("dnsat_hold0", c1, 0); check("dnsat_tch0", tc1, 1);
    cycle(); check("dnsat_hold1", c1, 0); check("dnsat_tch1", tc1, 1);

    // Priority and ovf set/clear collision.
    up = 1; sat = 0; max_val = 8'h55;
    clr = 1; load = 1; en = 1; load_val = 8'h55; cycle();
    check("prio_clr", c1, 0);
    clr = 0; cycle(); load = 0;
    check("prio_load", c1, 8'h55);
    check("prio_load_tc", tc1, 0);
    en = 0; ovf_clr = 1; cycle();
    check("ovf_clr_alone", ovf1, 0);
    load = 1; ovf_clr = 0; cycle(); load = 0;
    en = 1; ovf_clr = 1; cycle(); ovf_clr = 0;
    check("ovf_collide", ovf1, 1);
    check("ovf_collide_cnt", c1, 0);

    // Prescale 4 with an enable gap mid-phase.
    idle(); max_val = 8'd200; up = 1; sat = 0;
    clr = 1; cycle(); clr = 0; en = 1;
    for (int i = 0; i < 3; i++) begin cycle(); check("ps4_wait", c4, 0); end
    cycle(); check("ps4_first", c4, 1);
    cycle(); cycle();
    en = 0;
    for (int i = 0; i < 3; i++) begin cycle(); check("ps4_gap", c4, 1); end
    en = 1; cycle(); check("ps4_resume_a", c4, 1);
    cycle(); check("ps4_resume_b", c4, 2);

`ifdef PROG_COUNTER_CMP_EN
    idle(); cmp_val = 8'd5; load_val = 8'd5; load = 1; cycle(); load = 0;
    check("cmp_on_load", cm1, 1);
    en = 1; cycle(); check("cmp_off", cm1, 0);
`endif

    // Randomized traffic.
    idle();
    for (int n = 0; n < 3000; n++) begin
      en      = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 59) == 0);
      load    = ($urandom_range(0, 39) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) up = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) sat = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0)
        max_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 20));
      if ($urandom_range(0, 99) == 0) cmp_val = 8'($urandom_range(0, 20));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
